// File: rtl/periph_bus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : periph_bus_rr_arbiter
// Description : N-to-1 round-robin arbiter for the cluster peripheral bus.
//               Merges NUM_MASTERS req/gnt masters onto one slave port,
//               holds the winner until it is granted (lock), prefixes the
//               request ID with the winner index so responses can be routed
//               back, and caps the number of in-flight transactions.
// Ports       : clk_i / rst_i        clock, synchronous active-high reset
//               m_*_i / m_*_o        per-master request and response channels
//               s_*_o / s_*_i        shared slave request and response channels
//               outstanding_o        accepted-but-unanswered transaction count
//               err_o                sticky: response carried an invalid index
// Revision    : 1.0  initial release
// ============================================================================
module periph_bus_rr_arbiter #(
    parameter  int NUM_MASTERS     = 4,
    parameter  int ADDR_WIDTH      = 32,
    parameter  int DATA_WIDTH      = 32,
    parameter  int ID_WIDTH        = 9,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int BE_W            = DATA_WIDTH / 8,
    localparam int IDX_W           = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    localparam int SID_W           = ID_WIDTH + IDX_W,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    // master request channel
    input  logic [NUM_MASTERS-1:0]            m_req_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_add_i,
    input  logic [NUM_MASTERS-1:0]            m_wen_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
    input  logic [NUM_MASTERS*BE_W-1:0]       m_be_i,
    input  logic [NUM_MASTERS*ID_WIDTH-1:0]   m_id_i,
    output logic [NUM_MASTERS-1:0]            m_gnt_o,
    // master response channel
    output logic [NUM_MASTERS-1:0]            m_r_valid_o,
    output logic [NUM_MASTERS-1:0]            m_r_opc_o,
    output logic [NUM_MASTERS*ID_WIDTH-1:0]   m_r_id_o,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_r_rdata_o,
    // slave request channel
    output logic                              s_req_o,
    output logic [ADDR_WIDTH-1:0]             s_add_o,
    output logic                              s_wen_o,
    output logic [DATA_WIDTH-1:0]             s_wdata_o,
    output logic [BE_W-1:0]                   s_be_o,
    output logic [SID_W-1:0]                  s_id_o,
    input  logic                              s_gnt_i,
    // slave response channel
    input  logic                              s_r_valid_i,
    input  logic                              s_r_opc_i,
    input  logic [SID_W-1:0]                  s_r_id_i,
    input  logic [DATA_WIDTH-1:0]             s_r_rdata_i,
    // status
    output logic [CNT_W-1:0]                  outstanding_o,
    output logic                              err_o
);

    localparam logic [CNT_W-1:0] C_MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_MASTERS - 1);
    localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W:0]   C_NUM_EXT  = (IDX_W + 1)'(NUM_MASTERS);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] r_rr_ptr;
    logic             r_lock;
    logic [IDX_W-1:0] r_lock_idx;
    logic [CNT_W-1:0] r_count;
    logic             r_err;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [IDX_W:0]   w_cand;
    logic [IDX_W-1:0] w_arb_idx;
    logic [IDX_W-1:0] w_win;
    logic             w_any_req;
    logic             w_full;
    logic             w_req;
    logic             w_hs;
    logic [IDX_W-1:0] w_rsp_idx;
    logic             w_rsp_bad;

    // Round-robin search. Offsets are scanned from the farthest to the
    // nearest so that the last hit, i.e. the master closest to r_rr_ptr,
    // is the one that sticks. The extra bit on w_cand holds ptr+offset
    // before the modulo wrap, which works for non-power-of-2 counts.
    always_comb begin
        w_arb_idx = r_rr_ptr;
        w_cand    = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            w_cand = {1'b0, r_rr_ptr} + (IDX_W + 1)'(k);
            if (w_cand >= C_NUM_EXT) begin
                w_cand = w_cand - C_NUM_EXT;
            end
            if (m_req_i[w_cand[IDX_W-1:0]]) begin
                w_arb_idx = w_cand[IDX_W-1:0];
            end
        end
    end

    // While locked, only the held master may drive the slave port. Its
    // request alone qualifies s_req_o, so an illegally dropped locked
    // request never presents another master's fields under the wrong index.
    assign w_win     = r_lock ? r_lock_idx : w_arb_idx;
    assign w_any_req = r_lock ? m_req_i[r_lock_idx] : (|m_req_i);

    // A response in the same cycle frees a slot, so a full counter does
    // not block a request whose slot is being released right now.
    assign w_full = (r_count == C_MAX_CNT) && !s_r_valid_i;
    assign w_req  = w_any_req && !w_full;
    assign w_hs   = w_req && s_gnt_i;

    // Request mux and grant fan-out; all slave fields are zero when idle.
    always_comb begin
        s_req_o   = w_req;
        s_add_o   = '0;
        s_wen_o   = 1'b0;
        s_wdata_o = '0;
        s_be_o    = '0;
        s_id_o    = '0;
        m_gnt_o   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_req && (w_win == IDX_W'(i))) begin
                s_add_o    = m_add_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_wen_o    = m_wen_i[i];
                s_wdata_o  = m_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                s_be_o     = m_be_i[i*BE_W +: BE_W];
                s_id_o     = {w_win, m_id_i[i*ID_WIDTH +: ID_WIDTH]};
                m_gnt_o[i] = s_gnt_i;
            end
        end
    end

    // Response routing by the index carried in the upper ID bits.
    assign w_rsp_idx = s_r_id_i[SID_W-1:ID_WIDTH];
    assign w_rsp_bad = s_r_valid_i && (int'(w_rsp_idx) >= NUM_MASTERS);

    always_comb begin
        m_r_valid_o = '0;
        m_r_opc_o   = '0;
        m_r_id_o    = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_rsp_idx == IDX_W'(i)) begin
                m_r_valid_o[i]                    = s_r_valid_i;
                m_r_opc_o[i]                      = s_r_opc_i;
                m_r_id_o[i*ID_WIDTH +: ID_WIDTH]  = s_r_id_i[ID_WIDTH-1:0];
            end
        end
    end

    // Read data is broadcast; only the routed r_valid qualifies it.
    assign m_r_rdata_o = {NUM_MASTERS{s_r_rdata_i}};

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr   <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
        end else begin
            // Pointer advance and lock handling
            if (w_hs) begin
                r_rr_ptr <= (w_win == C_LAST_IDX) ? '0 : (w_win + C_IDX_ONE);
                r_lock   <= 1'b0;
            end else if (w_req) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_win;
            end else if (r_lock && !m_req_i[r_lock_idx]) begin
                r_lock <= 1'b0;
            end

            // In-flight counter. A handshake cannot occur while full, so
            // the count never exceeds MAX_OUTSTANDING; a stray response at
            // zero (e.g. after a reset mid-transaction) saturates.
            case ({w_hs, s_r_valid_i})
                2'b10: r_count <= r_count + C_CNT_ONE;
                2'b01: begin
                    if (r_count != '0) begin
                        r_count <= r_count - C_CNT_ONE;
                    end
                end
                default: ;
            endcase

            if (w_rsp_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign outstanding_o = r_count;
    assign err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_periph_bus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_periph_bus_rr_arbiter
// Description : Directed self-checking bench. Instance A uses 4 masters and
//               4 outstanding slots; instance B uses 3 masters and 2 slots.
// Revision    : 1.0  initial release
// ============================================================================
module tb_periph_bus_rr_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- instance A: N=4, MAX_OUTSTANDING=4 ----------------
    logic [3:0]   a_req, a_wen, a_gnt, a_rv, a_ropc;
    logic [127:0] a_add, a_wdata, a_rdata;
    logic [15:0]  a_be;
    logic [35:0]  a_id, a_rid;
    logic         a_sreq, a_swen, a_sgnt, a_srv, a_sropc, a_err;
    logic [31:0]  a_sadd, a_swdata, a_srdata;
    logic [3:0]   a_sbe;
    logic [10:0]  a_sid, a_srid;
    logic [2:0]   a_out;

    periph_bus_rr_arbiter #(
        .NUM_MASTERS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .ID_WIDTH(9), .MAX_OUTSTANDING(4)
    ) dut_a (
        .clk_i(clk), .rst_i(rst),
        .m_req_i(a_req), .m_add_i(a_add), .m_wen_i(a_wen),
        .m_wdata_i(a_wdata), .m_be_i(a_be), .m_id_i(a_id),
        .m_gnt_o(a_gnt), .m_r_valid_o(a_rv), .m_r_opc_o(a_ropc),
        .m_r_id_o(a_rid), .m_r_rdata_o(a_rdata),
        .s_req_o(a_sreq), .s_add_o(a_sadd), .s_wen_o(a_swen),
        .s_wdata_o(a_swdata), .s_be_o(a_sbe), .s_id_o(a_sid),
        .s_gnt_i(a_sgnt), .s_r_valid_i(a_srv), .s_r_opc_i(a_sropc),
        .s_r_id_i(a_srid), .s_r_rdata_i(a_srdata),
        .outstanding_o(a_out), .err_o(a_err)
    );

    // ---------------- instance B: N=3, MAX_OUTSTANDING=2 ----------------
    logic [2:0]   b_req, b_wen, b_gnt, b_rv, b_ropc;
    logic [95:0]  b_add, b_wdata, b_rdata;
    logic [11:0]  b_be;
    logic [26:0]  b_id, b_rid;
    logic         b_sreq, b_swen, b_sgnt, b_srv, b_sropc, b_err;
    logic [31:0]  b_sadd, b_swdata, b_srdata;
    logic [3:0]   b_sbe;
    logic [10:0]  b_sid, b_srid;
    logic [1:0]   b_out;

    periph_bus_rr_arbiter #(
        .NUM_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .ID_WIDTH(9), .MAX_OUTSTANDING(2)
    ) dut_b (
        .clk_i(clk), .rst_i(rst),
        .m_req_i(b_req), .m_add_i(b_add), .m_wen_i(b_wen),
        .m_wdata_i(b_wdata), .m_be_i(b_be), .m_id_i(b_id),
        .m_gnt_o(b_gnt), .m_r_valid_o(b_rv), .m_r_opc_o(b_ropc),
        .m_r_id_o(b_rid), .m_r_rdata_o(b_rdata),
        .s_req_o(b_sreq), .s_add_o(b_sadd), .s_wen_o(b_swen),
        .s_wdata_o(b_swdata), .s_be_o(b_sbe), .s_id_o(b_sid),
        .s_gnt_i(b_sgnt), .s_r_valid_i(b_srv), .s_r_opc_i(b_sropc),
        .s_r_id_i(b_srid), .s_r_rdata_i(b_srdata),
        .outstanding_o(b_out), .err_o(b_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] prev;
        rst = 1'b1;
        a_req = '0; a_wen = '0; a_sgnt = 1'b0; a_srv = 1'b0; a_sropc = 1'b0;
        a_srid = '0; a_srdata = '0; a_be = '1; a_wdata = '0;
        b_req = '0; b_wen = '0; b_sgnt = 1'b0; b_srv = 1'b0; b_sropc = 1'b0;
        b_srid = '0; b_srdata = '0; b_be = '1; b_wdata = '0;
        for (int i = 0; i < 4; i++) begin
            a_add[i*32 +: 32] = 32'h1000_0000 + 32'(i * 256);
            a_id[i*9 +: 9]    = 9'h050 + 9'(i);
        end
        for (int i = 0; i < 3; i++) begin
            b_add[i*32 +: 32] = 32'h2000_0000 + 32'(i * 256);
            b_id[i*9 +: 9]    = 9'h0A0 + 9'(i);
        end
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_out_a", 64'(a_out), 64'd0);
        chk("reset_gnt_a", 64'(a_gnt), 64'd0);
        chk("reset_sreq_a", 64'(a_sreq), 64'd0);
        chk("reset_err_a", 64'(a_err), 64'd0);
        chk("reset_out_b", 64'(b_out), 64'd0);
        chk("reset_err_b", 64'(b_err), 64'd0);

        // ---- single read from master 2 ----
        a_req = 4'b0100; a_wen = 4'b0100; a_sgnt = 1'b1;
        #1;
        chk("single_gnt", 64'(a_gnt), 64'h4);
        chk("single_sid", 64'(a_sid), 64'h452);
        chk("single_sadd", 64'(a_sadd), 64'h1000_0200);
        chk("single_swen", 64'(a_swen), 64'd1);
        tick();
        a_req = '0; a_sgnt = 1'b0;
        #1;
        chk("single_out1", 64'(a_out), 64'd1);
        chk("idle_sadd_zero", 64'(a_sadd), 64'd0);
        a_srv = 1'b1; a_srid = 11'h452; a_srdata = 32'hDEAD_BEEF;
        #1;
        chk("single_rvalid", 64'(a_rv), 64'h4);
        chk("single_rid", 64'(a_rid[26:18]), 64'h052);
        chk("single_rdata", 64'(a_rdata[95:64]), 64'hDEAD_BEEF);
        tick();
        a_srv = 1'b0;
        #1;
        chk("single_out0", 64'(a_out), 64'd0);

        // ---- all four request, grant every cycle, rotation from 0 ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_req = 4'hF; a_sgnt = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                prev   = 2'((k - 1) % 4);
                a_srv  = 1'b1;
                a_srid = {prev, 9'h000};
            end
            #1;
            chk("rr_gnt", 64'(a_gnt), 64'(4'b0001 << (k % 4)));
            tick();
        end
        a_req = '0; a_sgnt = 1'b0;
        a_srv = 1'b1; a_srid = {2'd0, 9'h000};
        tick();
        a_srv = 1'b0;
        #1;
        chk("rr_out0", 64'(a_out), 64'd0);

        // ---- lock: rr_ptr=1, master 3 stalled, master 1 joins ----
        a_req = 4'b1000; a_sgnt = 1'b0;
        #1;
        chk("lock_sreq", 64'(a_sreq), 64'd1);
        chk("lock_gnt0", 64'(a_gnt), 64'd0);
        chk("lock_idx0", 64'(a_sid[10:9]), 64'd3);
        tick();
        a_req = 4'b1010;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("lock_hold_idx", 64'(a_sid[10:9]), 64'd3);
            tick();
        end
        a_sgnt = 1'b1;
        #1;
        chk("lock_gnt3", 64'(a_gnt), 64'h8);
        tick();
        a_req = 4'b0010;
        #1;
        chk("after_lock_gnt1", 64'(a_gnt), 64'h2);
        tick();
        a_req = '0; a_sgnt = 1'b0;
        #1;
        chk("lock_out2", 64'(a_out), 64'd2);
        a_srv = 1'b1; a_srid = {2'd3, 9'h053};
        #1;
        chk("route_rv3", 64'(a_rv), 64'h8);
        chk("route_rid3", 64'(a_rid[35:27]), 64'h053);
        tick();
        a_srid = {2'd1, 9'h051};
        #1;
        chk("route_rv1", 64'(a_rv), 64'h2);
        tick();
        a_srv = 1'b0;
        #1;
        chk("route_out0", 64'(a_out), 64'd0);

        // ---- reset with 3 outstanding and an active lock ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_req = 4'b0001; a_sgnt = 1'b1;
        tick(); tick(); tick();
        #1;
        chk("pre_rst_out3", 64'(a_out), 64'd3);
        a_req = 4'b1100; a_sgnt = 1'b0;
        #1;
        chk("pre_rst_idx2", 64'(a_sid[10:9]), 64'd2);
        tick();
        rst = 1'b1; a_sgnt = 1'b1;
        tick();
        rst = 1'b0; a_sgnt = 1'b0; a_req = 4'b1101;
        #1;
        chk("post_rst_out", 64'(a_out), 64'd0);
        chk("post_rst_err", 64'(a_err), 64'd0);
        chk("post_rst_sreq", 64'(a_sreq), 64'd1);
        chk("post_rst_idx0", 64'(a_sid[10:9]), 64'd0);
        a_req = '0;
        tick();

        // ---- instance B: cap of 2 outstanding ----
        b_req = 3'b010; b_sgnt = 1'b1;
        #1;
        chk("cap_gnt_a", 64'(b_gnt), 64'h2);
        tick();
        #1;
        chk("cap_gnt_b", 64'(b_gnt), 64'h2);
        chk("cap_out1", 64'(b_out), 64'd1);
        tick();
        #1;
        chk("cap_out2", 64'(b_out), 64'd2);
        chk("cap_full_sreq", 64'(b_sreq), 64'd0);
        chk("cap_full_gnt", 64'(b_gnt), 64'd0);
        chk("cap_full_sadd", 64'(b_sadd), 64'd0);
        b_srv = 1'b1; b_srid = {2'd1, 9'h0A1};
        #1;
        chk("cap_free_sreq", 64'(b_sreq), 64'd1);
        chk("cap_free_gnt", 64'(b_gnt), 64'h2);
        chk("cap_free_rv", 64'(b_rv), 64'h2);
        tick();
        b_srv = 1'b0; b_req = '0; b_sgnt = 1'b0;
        #1;
        chk("cap_out_still2", 64'(b_out), 64'd2);

        // ---- instance B: out-of-range response index ----
        b_srv = 1'b1; b_srid = {2'd3, 9'h0A1};
        #1;
        chk("bad_rv_none", 64'(b_rv), 64'd0);
        tick();
        #1;
        chk("bad_err_set", 64'(b_err), 64'd1);
        chk("bad_out1", 64'(b_out), 64'd1);
        b_srid = {2'd1, 9'h0A1};
        tick();
        b_srv = 1'b0;
        #1;
        chk("bad_err_sticky", 64'(b_err), 64'd1);
        chk("bad_out0", 64'(b_out), 64'd0);
        b_srv = 1'b1;
        tick();
        b_srv = 1'b0;
        #1;
        chk("stray_sat0", 64'(b_out), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_err_clr", 64'(b_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
